// File: rtl/serial_signed_pow2_divider_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_signed_pow2_divider_pkg : FSM state encoding and mode constants
// Revision 1.0
// ----------------------------------------------------------------------------
package serial_signed_pow2_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BIAS  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_SHIFT = 1'b0;
  localparam logic MODE_DIV   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arith_shift_right_by_one.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arith_shift_right_by_one : combinational 1-bit arithmetic right shift
// Revision 1.0
// ----------------------------------------------------------------------------
module arith_shift_right_by_one #(
  parameter int N = 8
) (
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  assign q = {d[N-1], d[N-1:1]};

endmodule
`default_nettype wire

// File: rtl/serial_signed_pow2_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_signed_pow2_divider : signed divide by 2^k, one shift per cycle
// Revision 1.0
// ----------------------------------------------------------------------------
module serial_signed_pow2_divider
  import serial_signed_pow2_divider_pkg::*;
#(
  parameter int N  = 8,
  parameter int KW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  a,
  input  logic [KW-1:0] k,
  input  logic          mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  res,
  output logic          busy
);

  state_t        state;
  logic [N-1:0]  acc;
  logic [KW-1:0] cnt;
  logic          mode_q;
  logic [N-1:0]  acc_shr;
  logic [N-1:0]  bias;

  // Adding 2^k-1 to a negative dividend turns the floor shift into truncation.
  assign bias = (N'(1) << cnt) - N'(1);

  arith_shift_right_by_one #(
    .N(N)
  ) u_shift (
    .d(acc),
    .q(acc_shr)
  );

  assign up_ready   = (state == IDLE);
  assign down_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign res        = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      mode_q <= MODE_SHIFT;
    end else begin
      case (state)
        IDLE: begin
          if (up_valid) begin
            acc    <= a;
            cnt    <= k;
            mode_q <= mode;
            if (mode == MODE_DIV && a[N-1] && k != '0)
              state <= BIAS;
            else if (k != '0)
              state <= SHIFT;
            else
              state <= DONE;
          end
        end
        BIAS: begin
          if (mode_q == MODE_DIV)
            acc <= acc + bias;
          state <= SHIFT;
        end
        SHIFT: begin
          acc <= acc_shr;
          cnt <= cnt - KW'(1);
          if (cnt == KW'(1))
            state <= DONE;
        end
        DONE: begin
          if (down_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
